// File: rtl/spi_write_arbiter.sv
// spi_write_arbiter: round-robin SPI write master shared by NREQ requesters.
// Ports: clk, rst_n; req/addr/data per requester in; ack, busy, CS/SCLK/SDATA out.
module spi_write_arbiter #(
   parameter int NREQ   = 2,
   parameter int CLKDIV = 25
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [8*NREQ-1:0] addr,
   input  logic [8*NREQ-1:0] data,
   output logic [NREQ-1:0]   ack,
   output logic              busy,
   output logic              CS,
   output logic              SCLK,
   output logic              SDATA
);
   localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_SHIFT, S_TAIL, S_GAP
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;
   logic [PW-1:0]   r_ptr, w_ptr_nxt;
   logic [PW-1:0]   r_gnt, w_gnt_nxt;
   logic [15:0]     r_shift, w_shift_nxt;
   logic [3:0]      r_bit, w_bit_nxt;
   logic            r_ph, w_ph_nxt;
   logic [NREQ-1:0] r_ack, w_ack_nxt;
   logic            r_busy, w_busy_nxt;
   logic            r_cs, w_cs_nxt;
   logic            r_sclk, w_sclk_nxt;
   logic            r_sdata, w_sdata_nxt;

   logic              w_tick;
   logic [2*NREQ-1:0] w_req2;
   logic [NREQ-1:0]   w_rot;
   logic [PW-1:0]     w_off;
   logic [PW:0]       w_sum;
   logic [PW-1:0]     w_sel;
   logic [15:0]       w_word;

   assign w_tick = (r_cnt == CW'(CLKDIV - 1));

   // Rotate requests so bit 0 is the requester at the rr pointer;
   // the lowest set bit of the rotated vector is the winner.
   assign w_req2 = {req, req} >> r_ptr;
   assign w_rot  = w_req2[NREQ-1:0];

   always_comb begin
      w_off = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (w_rot[k]) w_off = PW'(k);
      end
   end

   assign w_sum = {1'b0, r_ptr} + {1'b0, w_off};
   assign w_sel = (w_sum >= (PW+1)'(NREQ)) ?
                  PW'(w_sum - (PW+1)'(NREQ)) : w_sum[PW-1:0];

   always_comb begin
      w_word = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_sel == PW'(i)) w_word = {addr[8*i +: 8], data[8*i +: 8]};
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = w_tick ? '0 : r_cnt + 1'b1;
      w_ptr_nxt   = r_ptr;
      w_gnt_nxt   = r_gnt;
      w_shift_nxt = r_shift;
      w_bit_nxt   = r_bit;
      w_ph_nxt    = r_ph;
      w_ack_nxt   = '0;
      w_busy_nxt  = r_busy;
      w_cs_nxt    = r_cs;
      w_sclk_nxt  = r_sclk;
      w_sdata_nxt = r_sdata;
      unique case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            if (|req) begin
               w_gnt_nxt   = w_sel;
               w_shift_nxt = w_word;
               w_cs_nxt    = 1'b0;
               w_busy_nxt  = 1'b1;
               w_state_nxt = S_SETUP;
            end
         end
         S_SETUP: begin
            if (w_tick) begin
               w_sdata_nxt = r_shift[15];
               w_sclk_nxt  = 1'b0;
               w_bit_nxt   = '0;
               w_ph_nxt    = 1'b0;
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (w_tick) begin
               if (!r_ph) begin
                  w_sclk_nxt = 1'b1;
                  w_ph_nxt   = 1'b1;
               end else begin
                  // Data moves only together with the falling SCLK.
                  w_sclk_nxt  = 1'b0;
                  w_ph_nxt    = 1'b0;
                  w_shift_nxt = r_shift << 1;
                  w_bit_nxt   = r_bit + 1'b1;
                  if (r_bit == 4'd15) begin
                     w_sdata_nxt = 1'b0;
                     w_state_nxt = S_TAIL;
                  end else begin
                     w_sdata_nxt = r_shift[14];
                  end
               end
            end
         end
         S_TAIL: begin
            if (w_tick) begin
               w_cs_nxt    = 1'b1;
               w_state_nxt = S_GAP;
            end
         end
         S_GAP: begin
            if (w_tick) begin
               w_ack_nxt[r_gnt] = 1'b1;
               w_busy_nxt       = 1'b0;
               w_ptr_nxt        = (r_gnt == PW'(NREQ - 1)) ?
                                  '0 : r_gnt + 1'b1;
               w_state_nxt      = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_ptr   <= '0;
         r_gnt   <= '0;
         r_shift <= '0;
         r_bit   <= '0;
         r_ph    <= 1'b0;
         r_ack   <= '0;
         r_busy  <= 1'b0;
         r_cs    <= 1'b1;
         r_sclk  <= 1'b0;
         r_sdata <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ptr   <= w_ptr_nxt;
         r_gnt   <= w_gnt_nxt;
         r_shift <= w_shift_nxt;
         r_bit   <= w_bit_nxt;
         r_ph    <= w_ph_nxt;
         r_ack   <= w_ack_nxt;
         r_busy  <= w_busy_nxt;
         r_cs    <= w_cs_nxt;
         r_sclk  <= w_sclk_nxt;
         r_sdata <= w_sdata_nxt;
      end
   end

   assign ack   = r_ack;
   assign busy  = r_busy;
   assign CS    = r_cs;
   assign SCLK  = r_sclk;
   assign SDATA = r_sdata;

endmodule

// File: tb/tb_spi_write_arbiter.sv
// tb_spi_write_arbiter: random + directed bench for spi_write_arbiter.
// Frame-level model predicts every output from cycles-since-grant.
module tb_spi_write_arbiter;
   localparam int N  = 2;
   localparam int C  = 4;
   localparam int FR = 35 * C;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  req;
   logic [15:0]   addr, data;
   logic [N-1:0]  ack;
   logic          busy, CS, SCLK, SDATA;

   logic [1:0]    f_req;
   logic [15:0]   f_addr, f_data;
   logic [1:0]    f_ack;
   logic          f_busy, f_cs, f_sclk, f_sdata;

   always #5 clk = ~clk;

   spi_write_arbiter #(.NREQ(N), .CLKDIV(C)) u_dut (
      .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .data(data),
      .ack(ack), .busy(busy), .CS(CS), .SCLK(SCLK), .SDATA(SDATA)
   );

   spi_write_arbiter #(.NREQ(2), .CLKDIV(1)) u_fast (
      .clk(clk), .rst_n(rst_n), .req(f_req), .addr(f_addr),
      .data(f_data), .ack(f_ack), .busy(f_busy), .CS(f_cs),
      .SCLK(f_sclk), .SDATA(f_sdata)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // ---------------- model + per-cycle compare ----------------
   bit           m_act;
   int           m_d, m_g, m_ptr, m_idx, h;
   logic [15:0]  m_word;
   logic [N-1:0] m_ack;
   logic         e_cs, e_sclk, e_sd, e_busy;
   logic [15:0]  mon_bits, last_bits;
   int           mon_rises, last_rises;
   logic         mon_psclk;
   int           ackq[$];

   always begin
      @(posedge clk);
      m_ack = '0;
      if (!rst_n) begin
         m_act = 0; m_d = 0; m_ptr = 0;
      end else if (m_act) begin
         m_d++;
         if (m_d == FR) begin
            m_act = 0;
            m_ack[m_g] = 1'b1;
            m_ptr = (m_g + 1) % N;
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            m_idx = (m_ptr + k) % N;
            if (!m_act && req[m_idx]) begin
               m_act  = 1;
               m_d    = 0;
               m_g    = m_idx;
               m_word = {addr[8*m_idx +: 8], data[8*m_idx +: 8]};
            end
         end
      end
      #1;
      if (m_act) begin
         h      = m_d / C;
         e_busy = 1'b1;
         e_cs   = (h < 34) ? 1'b0 : 1'b1;
         e_sclk = (h >= 1 && h <= 32 && ((h - 1) % 2 == 1));
         e_sd   = (h >= 1 && h <= 32) ? m_word[15 - (h - 1) / 2] : 1'b0;
      end else begin
         e_busy = 1'b0; e_cs = 1'b1; e_sclk = 1'b0; e_sd = 1'b0;
      end
      chk("cycle", {ack, busy, CS, SCLK, SDATA},
          {m_ack, e_busy, e_cs, e_sclk, e_sd});
      if (!rst_n) begin
         mon_bits = '0; mon_rises = 0; mon_psclk = 1'b0;
      end else begin
         if (!mon_psclk && SCLK) begin
            mon_bits = {mon_bits[14:0], SDATA};
            mon_rises++;
         end
         if (ack != '0) begin
            for (int i = 0; i < N; i++) if (ack[i]) ackq.push_back(i);
            chk("frame_bits", mon_bits, m_word);
            chk("frame_rises", mon_rises, 16);
            last_bits  = mon_bits;
            last_rises = mon_rises;
            mon_bits   = '0;
            mon_rises  = 0;
         end
         mon_psclk = SCLK;
      end
   end

   // ---------------- stimulus helpers ----------------
   logic [N-1:0] hold;

   task automatic tick();
      @(negedge clk);
      for (int i = 0; i < N; i++)
         if (ack[i] && !hold[i]) req[i] = 1'b0;
   endtask

   task automatic wait_ack(input int i, input int lim, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!ack[i] && n < lim);
      chk($sformatf("ack%0d_seen", i), ack[i], 1'b1);
   endtask

   task automatic wait_idle(input int lim);
      int n = 0;
      while ((busy || req != '0) && n < lim) begin
         tick();
         n++;
      end
      chk("idle_reached", busy, 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      hold  = '0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   // ---------------- directed + random tests ----------------
   initial begin : stim
      int n, nhi, nack, viol, badsp, lastrise;
      logic [15:0] fb;
      logic psclk, psd;
      int frises;
      rst_n = 1'b0; req = '0; addr = '0; data = '0; hold = '0;
      f_req = '0; f_addr = '0; f_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_cs", CS, 1'b1);
      chk("rst_sclk_sdata", {SCLK, SDATA}, 2'b00);
      chk("rst_busy_ack", {busy, ack}, 3'b000);
      rst_n = 1'b1;
      tick();

      // single frame, A5/3C
      addr[7:0] = 8'hA5; data[7:0] = 8'h3C; req[0] = 1'b1;
      wait_ack(0, 300, n);
      chk("t1_len", n - 1, 140);
      chk("t1_bits", last_bits, 16'hA53C);
      chk("t1_rises", last_rises, 16);
      tick();
      chk("t1_ack_pulse", ack, 2'b00);
      chk("t1_busy", busy, 1'b0);

      // simultaneous requests from pointer 0
      do_reset();
      ackq.delete();
      addr = 16'h2211; data = 16'h4433; req = 2'b11;
      tick();
      n = 0;
      while (!CS && n < 300) begin tick(); n++; end
      nhi = 0;
      while (CS && nhi < 300) begin nhi++; tick(); end
      chk("t2_cs_gap", nhi, C + 1);
      wait_ack(1, 300, n);
      chk("t2_nack", ackq.size(), 2);
      if (ackq.size() >= 2) begin
         chk("t2_first", ackq[0], 0);
         chk("t2_second", ackq[1], 1);
      end

      // req0 held, req1 arrives mid-frame
      do_reset();
      ackq.delete();
      hold[0] = 1'b1;
      addr = 16'h3311; data = 16'h4422; req[0] = 1'b1;
      repeat (20) tick();
      req[1] = 1'b1;
      n = 0;
      while (ackq.size() < 3 && n < 4 * FR) begin tick(); n++; end
      chk("t3_nack", ackq.size() >= 3, 1'b1);
      if (ackq.size() >= 3) begin
         chk("t3_order", {ackq[0][1:0], ackq[1][1:0], ackq[2][1:0]},
             6'b00_01_00);
      end
      hold[0] = 1'b0;
      req[0]  = 1'b0;
      wait_idle(300);

      // reset during bit 7 of the shift phase
      addr[7:0] = 8'hA5; data[7:0] = 8'h3C; req[0] = 1'b1;
      repeat (63) tick();
      chk("t4_busy_before", busy, 1'b1);
      nack  = ackq.size();
      rst_n = 1'b0;
      #1;
      chk("t4_cs", CS, 1'b1);
      chk("t4_sclk_sdata", {SCLK, SDATA}, 2'b00);
      chk("t4_busy", busy, 1'b0);
      addr[7:0] = 8'h5A; data[7:0] = 8'hC3;
      repeat (3) tick();
      chk("t4_no_ack", ackq.size(), nack);
      rst_n = 1'b1;
      wait_ack(0, 300, n);
      chk("t4_len", n - 1, 140);
      chk("t4_bits", last_bits, 16'h5AC3);
      wait_idle(300);

      // inputs change and req drops after grant
      addr[7:0] = 8'h11; data[7:0] = 8'h22; req[0] = 1'b1;
      tick();
      tick();
      req[0] = 1'b0; addr[7:0] = 8'hFF; data[7:0] = 8'h00;
      wait_ack(0, 300, n);
      chk("t6_bits", last_bits, 16'h1122);
      wait_idle(300);

      // CLKDIV=1 instance: 00/FF frame
      f_addr[7:0] = 8'h00; f_data[7:0] = 8'hFF; f_req[0] = 1'b1;
      n = 0; viol = 0; badsp = 0; frises = 0; fb = '0;
      psclk = 1'b0; psd = 1'b0; lastrise = -1;
      do begin
         @(negedge clk);
         n++;
         if (!psclk && f_sclk) begin
            fb = {fb[14:0], f_sdata};
            frises++;
            if (lastrise >= 0 && n - lastrise != 2) badsp++;
            lastrise = n;
         end
         if (f_sclk && f_sdata !== psd) viol++;
         psclk = f_sclk;
         psd   = f_sdata;
      end while (!f_ack[0] && n < 100);
      f_req[0] = 1'b0;
      chk("t5_ack", f_ack[0], 1'b1);
      chk("t5_len", n - 1, 35);
      chk("t5_bits", fb, 16'h00FF);
      chk("t5_rises", frises, 16);
      chk("t5_sclk_period", badsp, 0);
      chk("t5_sdata_stable", viol, 0);
      @(negedge clk);
      chk("t5_ack_pulse", f_ack, 2'b00);

      // random traffic against the model
      for (int cyc = 0; cyc < 3000; cyc++) begin
         tick();
         for (int i = 0; i < N; i++) begin
            if (!req[i] && $urandom_range(0, 19) == 0) begin
               addr[8*i +: 8] = 8'($urandom);
               data[8*i +: 8] = 8'($urandom);
               req[i] = 1'b1;
            end else if ($urandom_range(0, 7) == 0) begin
               addr[8*i +: 8] = 8'($urandom);
               data[8*i +: 8] = 8'($urandom);
            end
         end
      end
      wait_idle(4 * FR);
      chk("rand_frames", ackq.size() > 20, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      n_err++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $fatal(1, "watchdog");
   end

endmodule
